// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the data cache.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package dcache_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL_REQ,
    ST_REFILL_WAIT,
    ST_STORE_REQ,
    ST_STORE_WAIT,
    ST_RESP
  } dcache_state_t;

  // Byte-offset bits within a line.
  function automatic int dcache_offset_w(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int dcache_index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int dcache_tag_w(input int addr_w, input int line_words, input int num_lines);
    return addr_w - dcache_offset_w(line_words) - dcache_index_w(num_lines);
  endfunction

endpackage

// File: rtl/dcache_data_align.sv
// Load byte/half extraction with sign/zero extension; store lane replication and strobes.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module dcache_data_align
  import dcache_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  byte_off,
  input  mem_size_t   acc_size,
  input  logic        ld_sign,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Select the addressed byte/half of the word and extend it to 32 bits.
  always_comb begin
    ld_byte = 8'(ld_word >> {byte_off, 3'b000});
    ld_half = 16'(ld_word >> {byte_off[1], 4'b0000});
    case (acc_size)
      MEM_SIZE_B: ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
      MEM_SIZE_H: ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
      default:    ld_data = ld_word;
    endcase
  end

  // Replicate low-aligned store data into every lane and strobe only the addressed bytes.
  always_comb begin
    case (acc_size)
      MEM_SIZE_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << byte_off;
      end
      MEM_SIZE_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << {byte_off[1], 1'b0};
      end
      default: begin
        st_wdata = st_data;
        st_wstrb = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-through, no-write-allocate data cache for the memory stage.
// Latency: load hit 2 cycles; miss 2+3*LINE_WORDS and store 5 with a 1-cycle-ready memory.
// Backpressure: resp_ready low while busy (requests ignored); mem_req_valid held until mem_req_ready.
module dcache
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  mem_size_t             size,
  input  logic                  sign,
  output logic                  resp_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int OFF_W  = dcache_offset_w(LINE_WORDS);
  localparam int IDX_W  = dcache_index_w(NUM_LINES);
  localparam int TAG_W  = dcache_tag_w(ADDR_WIDTH, LINE_WORDS, NUM_LINES);
  localparam int WSEL_W = OFF_W - 2;

  dcache_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, req_addr_al;
  logic                  we_q, we_d, sign_q, sign_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, resp_data_q, resp_data_d;
  mem_size_t             size_q, size_d;
  logic [WSEL_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;

  logic [DATA_WIDTH-1:0] data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];

  logic [TAG_W-1:0]      tag;
  logic [IDX_W-1:0]      idx;
  logic [WSEL_W-1:0]     wsel;
  logic                  hit;
  logic [DATA_WIDTH-1:0] line_word, ld_word, ld_data, st_wdata, st_mask;
  logic [3:0]            st_wstrb;
  logic                  arr_we, tag_we;
  logic [WSEL_W-1:0]     arr_wsel;
  logic [DATA_WIDTH-1:0] arr_wdat;

  assign tag        = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign idx        = addr_q[OFF_W +: IDX_W];
  assign wsel       = addr_q[2 +: WSEL_W];
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign line_word  = data_q[idx][wsel];
  // On the last refill beat the requested word may still be on mem_rdata rather than in the array.
  assign ld_word    = (state_q == ST_REFILL_WAIT && cnt_q == wsel) ? mem_rdata : line_word;
  assign st_mask    = {{8{st_wstrb[3]}}, {8{st_wstrb[2]}}, {8{st_wstrb[1]}}, {8{st_wstrb[0]}}};
  assign resp_ready = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = resp_data_q;

  dcache_data_align u_align (
    .ld_word  (ld_word),
    .byte_off (addr_q[1:0]),
    .acc_size (size_q),
    .ld_sign  (sign_q),
    .st_data  (wdata_q),
    .ld_data  (ld_data),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb)
  );

  // Naturally align the incoming address by clearing the low bits the access size ignores.
  always_comb begin
    req_addr_al = req_addr;
    if (size == MEM_SIZE_H) req_addr_al[0] = 1'b0;
    else if (size == MEM_SIZE_W) req_addr_al[1:0] = 2'b00;
  end

  // Next-state, request capture, array write controls and valid-bit updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    valid_d     = valid_q;
    arr_we      = 1'b0;
    arr_wsel    = cnt_q;
    arr_wdat    = mem_rdata;
    tag_we      = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        addr_d  = req_addr_al;
        we_d    = write_en;
        wdata_d = write_data;
        size_d  = size;
        sign_d  = sign;
        state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (we_q) begin
          // Store hits update the line in place; misses leave the array alone.
          if (hit) begin
            arr_we   = 1'b1;
            arr_wsel = wsel;
            arr_wdat = (line_word & ~st_mask) | (st_wdata & st_mask);
          end
          state_d = ST_STORE_REQ;
        end else if (hit) begin
          resp_data_d = ld_data;
          state_d     = ST_RESP;
        end else begin
          valid_d[idx] = 1'b0;
          cnt_d        = '0;
          state_d      = ST_REFILL_REQ;
        end
      end
      ST_REFILL_REQ: if (mem_req_ready) state_d = ST_REFILL_WAIT;
      ST_REFILL_WAIT: if (mem_resp_valid) begin
        arr_we = 1'b1;
        if (cnt_q == WSEL_W'(LINE_WORDS - 1)) begin
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          resp_data_d  = ld_data;
          state_d      = ST_RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_REFILL_REQ;
        end
      end
      ST_STORE_REQ: if (mem_req_ready) state_d = ST_STORE_WAIT;
      ST_STORE_WAIT: if (mem_resp_valid) begin
        resp_data_d = '0;
        state_d     = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-side request; fields come from registered state so they hold until accepted.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_write_en  = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    if (state_q == ST_REFILL_REQ) begin
      mem_req_valid = 1'b1;
      mem_addr      = {addr_q[ADDR_WIDTH-1:OFF_W], cnt_q, 2'b00};
    end else if (state_q == ST_STORE_REQ) begin
      mem_req_valid = 1'b1;
      mem_write_en  = 1'b1;
      mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      mem_wdata     = st_wdata;
      mem_wstrb     = st_wstrb;
    end
  end

  // Control state and valid bits; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      size_q      <= MEM_SIZE_B;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      valid_q     <= valid_d;
    end
  end

  // Data and tag storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (arr_we) data_q[idx][arr_wsel] <= arr_wdat;
    if (tag_we) tag_q[idx] <= tag;
  end

endmodule
